// File: rtl/mul8_inv_div16by8_seq.sv
// Sequential radix-2 restoring divider: 2W-bit dividend / W-bit divisor -> W-bit quotient and remainder.
// Used as the exact inverse of the 8x8 multipliers; one quotient bit per clock, valid/ready on both sides.
module mul8_inv_div16by8_seq #(
  parameter int unsigned WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [2*WIDTH-1:0]   P,
  input  logic [WIDTH-1:0]     B,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     Q,
  output logic [WIDTH-1:0]     R,
  output logic                 dbz,
  output logic                 ovf
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state;
  logic [WIDTH-1:0]   b_reg;
  logic [WIDTH-1:0]   rem;
  logic [WIDTH-1:0]   shreg;
  logic [CW-1:0]      cnt;

  logic [WIDTH-1:0]   p_hi;
  logic [WIDTH:0]     trial;
  logic               q_bit;
  logic [WIDTH-1:0]   rem_next;
  logic [WIDTH-1:0]   shreg_next;

  assign p_hi = P[2*WIDTH-1:WIDTH];

  // One restoring step; rem stays below b_reg, so it needs only W bits between steps.
  // shreg shifts dividend bits out at the MSB while quotient bits enter at the LSB.
  always_comb begin
    trial      = {rem, shreg[WIDTH-1]};
    q_bit      = 1'b0;
    rem_next   = trial[WIDTH-1:0];
    shreg_next = {shreg[WIDTH-2:0], 1'b0};
    if (trial >= {1'b0, b_reg}) begin
      q_bit    = 1'b1;
      rem_next = WIDTH'(trial - {1'b0, b_reg});
    end
    shreg_next = {shreg[WIDTH-2:0], q_bit};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      Q         <= '0;
      R         <= '0;
      dbz       <= 1'b0;
      ovf       <= 1'b0;
      b_reg     <= '0;
      rem       <= '0;
      shreg     <= '0;
      cnt       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            b_reg    <= B;
            in_ready <= 1'b0;
            if (B == '0) begin
              state     <= DONE;
              out_valid <= 1'b1;
              dbz       <= 1'b1;
              ovf       <= 1'b0;
              Q         <= '1;
              R         <= '0;
            end else if (p_hi >= B) begin
              // Quotient would not fit in W bits.
              state     <= DONE;
              out_valid <= 1'b1;
              dbz       <= 1'b0;
              ovf       <= 1'b1;
              Q         <= '1;
              R         <= '0;
            end else begin
              state <= RUN;
              rem   <= p_hi;
              shreg <= P[WIDTH-1:0];
              cnt   <= CW'(WIDTH);
            end
          end
        end
        RUN: begin
          rem   <= rem_next;
          shreg <= shreg_next;
          cnt   <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            state     <= DONE;
            out_valid <= 1'b1;
            Q         <= shreg_next;
            R         <= rem_next;
            dbz       <= 1'b0;
            ovf       <= 1'b0;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

endmodule
